latent_sample_ctrl: RTL and testbench

Sequencing controller for the latent sampling stage of the hidden layer. It accepts one mean/raw-variance pair per latent dimension and fetches a noise sample from the epsilon source. It obtains the standard deviation (softplus then square root) from the shared std-dev unit, then computes z = mean + sd * epsilon internally. Results stream out one dimension at a time, and the std-dev unit and epsilon generator are each used by only one dimension at a time.

---
 rtl/latent_sample_ctrl.sv | 162 ++++++++++++++++
 tb/tb_latent_sample_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/latent_sample_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : latent_sample_ctrl
//  Description : Latent-stage sequencer; computes z = mean + sd * eps per dim.
//  Revision    : 1.0  initial release
// ============================================================================
module latent_sample_ctrl #(
    parameter  int W     = 20,
    parameter  int FRAC  = 10,
    parameter  int N_LAT = 2,
    localparam int IW    = (N_LAT > 1) ? $clog2(N_LAT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_mean,
    input  logic [W-1:0]  in_var,
    output logic          eps_req,
    input  logic          eps_ack,
    input  logic [W-1:0]  eps_data,
    output logic          sd_req,
    output logic [W-1:0]  sd_var,
    input  logic          sd_ack,
    input  logic [W-1:0]  sd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic [W-1:0]  out_z,
    output logic          sat
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_MAC   = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    localparam int SW = 2 * W + 1;
    localparam logic signed [SW-1:0] c_sum_max = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] c_sum_min = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic [W-1:0]         c_z_max   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]         c_z_min   = {1'b1, {(W-1){1'b0}}};
    localparam logic [IW-1:0]        c_last    = IW'(N_LAT - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [W-1:0]           r_mean;
    logic [W-1:0]           r_eps;
    logic [W-1:0]           r_sd;
    logic [2*W-1:0]         w_prod;
    logic signed [2*W-1:0]  w_q;
    logic signed [SW-1:0]   w_sum;
    logic [W-1:0]           w_z;
    logic                   w_sat;

    // Low 2W bits of the product of sign-extended operands equal the signed product.
    always_comb begin
        w_prod = {{W{r_sd[W-1]}}, r_sd} * {{W{r_eps[W-1]}}, r_eps};
        w_q    = $signed(w_prod) >>> FRAC;
        w_sum  = {{(SW-W){r_mean[W-1]}}, r_mean} + {w_q[2*W-1], w_q};
        w_z    = w_sum[W-1:0];
        w_sat  = 1'b0;
        if (w_sum > c_sum_max) begin
            w_z   = c_z_max;
            w_sat = 1'b1;
        end else if (w_sum < c_sum_min) begin
            w_z   = c_z_min;
            w_sat = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_FETCH;
            end
            // A request already low means its data was captured earlier.
            S_FETCH: if ((!eps_req || eps_ack) && (!sd_req || sd_ack)) w_state_nxt = S_MAC;
            S_MAC:   w_state_nxt = S_OUT;
            S_OUT:   if (out_ready) w_state_nxt = (out_idx == c_last) ? S_IDLE : S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mean    <= '0;
            r_eps     <= '0;
            r_sd      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eps_req   <= 1'b0;
            sd_req    <= 1'b0;
            sd_var    <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_z     <= '0;
            sat       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        sat     <= 1'b0;
                        out_idx <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_mean  <= in_mean;
                        sd_var  <= in_var;
                        eps_req <= 1'b1;
                        sd_req  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (eps_req && eps_ack) begin
                        r_eps   <= eps_data;
                        eps_req <= 1'b0;
                    end
                    if (sd_req && sd_ack) begin
                        r_sd   <= sd_data;
                        sd_req <= 1'b0;
                    end
                end
                S_MAC: begin
                    out_z     <= w_z;
                    sat       <= sat | w_sat;
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_idx == c_last) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            out_idx <= out_idx + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_latent_sample_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_latent_sample_ctrl
//  Description : Self-checking bench for latent_sample_ctrl against a floor-division model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_latent_sample_ctrl;

    localparam int     W     = 20;
    localparam int     FRAC  = 10;
    localparam int     N_LAT = 2;
    localparam int     IW    = 1;
    localparam longint ZMAX  = (longint'(1) << (W - 1)) - 1;
    localparam longint ZMIN  = -(longint'(1) << (W - 1));

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_mean = '0, in_var = '0;
    logic          eps_req;
    logic          eps_ack = 1'b0;
    logic [W-1:0]  eps_data = '0;
    logic          sd_req;
    logic          sd_ack = 1'b0;
    logic [W-1:0]  sd_var;
    logic [W-1:0]  sd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_idx;
    logic [W-1:0]  out_z;
    logic          sat;

    int           n_chk = 0, n_err = 0, cyc = 0;
    logic [W-1:0] eps_val = '0, sd_val = '0;
    int           eps_dly = 0, sd_dly = 0, eps_cnt = 0, sd_cnt = 0;
    int           eps_ack_cyc = 0, sd_ack_cyc = 0;
    bit           exp_sat = 1'b0;

    latent_sample_ctrl #(.W(W), .FRAC(FRAC), .N_LAT(N_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_mean(in_mean), .in_var(in_var),
        .eps_req(eps_req), .eps_ack(eps_ack), .eps_data(eps_data),
        .sd_req(sd_req), .sd_var(sd_var), .sd_ack(sd_ack), .sd_data(sd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_z(out_z), .sat(sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // z = mean + floor(sd*eps / 2^FRAC), then clamped to the W-bit signed range.
    function automatic longint model_raw(longint m, longint s, longint e);
        longint p, q, d;
        d = longint'(1) << FRAC;
        p = s * e;
        q = p / d;
        if ((p % d) != 0 && p < 0) q = q - 1;
        return m + q;
    endfunction

    function automatic longint clamp(longint v);
        if (v > ZMAX) return ZMAX;
        if (v < ZMIN) return ZMIN;
        return v;
    endfunction

    function automatic longint rnd(int bits);
        longint u;
        u = longint'($urandom) % (longint'(1) << bits);
        return u - (longint'(1) << (bits - 1));
    endfunction

    // Epsilon source: answers each request after eps_dly wait cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                eps_ack = 1'b0;
                eps_cnt = 0;
            end else if (eps_ack) begin
                eps_ack = 1'b0;
                eps_cnt = 0;
                check("eps_req_drop", eps_req, 0);
            end else if (eps_req) begin
                if (eps_cnt >= eps_dly) begin
                    eps_ack     = 1'b1;
                    eps_data    = eps_val;
                    eps_ack_cyc = cyc;
                end else eps_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sd_ack = 1'b0;
                sd_cnt = 0;
            end else if (sd_ack) begin
                sd_ack = 1'b0;
                sd_cnt = 0;
                check("sd_req_drop", sd_req, 0);
            end else if (sd_req) begin
                if (sd_cnt >= sd_dly) begin
                    sd_ack     = 1'b1;
                    sd_data    = sd_val;
                    sd_ack_cyc = cyc;
                end else sd_cnt++;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);         check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0); check("rst_eps_req", eps_req, 0);
        check("rst_sd_req", sd_req, 0);     check("rst_sd_var", sd_var, 0);
        check("rst_out_valid", out_valid, 0); check("rst_out_idx", out_idx, 0);
        check("rst_out_z", out_z, 0);       check("rst_sat", sat, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_in_ready", in_ready, 1);
        check("start_sat_clr", sat, 0);
        exp_sat = 1'b0;
    endtask

    task automatic do_dim(input longint m, input longint v, input longint s, input longint e,
                          input int edly, input int sdly, input int idx, input bit last, input int hold);
        longint raw, z;
        int n;
        raw = model_raw(m, s, e);
        z   = clamp(raw);
        if (z != raw) exp_sat = 1'b1;
        eps_val  = e[W-1:0];
        sd_val   = s[W-1:0];
        eps_dly  = edly;
        sd_dly   = sdly;
        in_mean  = m[W-1:0];
        in_var   = v[W-1:0];
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check("in_ready_wait", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("fetch_reqs", {eps_req, sd_req}, 2'b11);
        check("sd_var", $signed(sd_var), v);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        check("out_valid_wait", out_valid, 1);
        check("out_latency", cyc, ((eps_ack_cyc > sd_ack_cyc) ? eps_ack_cyc : sd_ack_cyc) + 2);
        check("out_z", $signed(out_z), z);
        check("out_idx", out_idx, idx);
        check("sat_live", sat, exp_sat);
        for (int k = 0; k < hold; k++) begin
            start = (k == 3);
            @(negedge clk);
            check("hold_z", $signed(out_z), z);
            check("hold_idx", out_idx, idx);
            check("hold_valid", out_valid, 1);
            check("hold_no_load", in_ready, 0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        if (last) begin
            check("done_pulse", done, 1);
            check("busy_off", busy, 0);
        end else begin
            check("done_mid", done, 0);
            check("next_load", in_ready, 1);
        end
    endtask

    task automatic run2(input longint m0, input longint s0, input longint e0, input int ed0, input int sd0,
                        input longint m1, input longint s1, input longint e1, input int ed1, input int sd1,
                        input int hold);
        do_start();
        do_dim(m0, rnd(W), s0, e0, ed0, sd0, 0, 1'b0, hold);
        do_dim(m1, rnd(W), s1, e1, ed1, sd1, 1, 1'b1, 0);
        check("sat_end", sat, exp_sat);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Basic, then floor rounding, then saturation both ways.
        run2(1024, 512, 2048, 0, 0,  0, 1024, -1024, 0, 0, 0);
        check("basic_sat", sat, 0);
        run2(0, 1, 1, 0, 0,  0, 1, -1, 1, 1, 0);
        run2(524287, 1024, 1024, 0, 0,  -524288, 1024, -1024, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("sat_sticky", sat, 1);

        // Ack ordering both ways, with backpressure and a stray start.
        run2(300, 700, -900, 0, 5,  -50, 2000, 333, 5, 0, 10);

        // Reset while requests are outstanding.
        do_start();
        eps_dly  = 30;
        sd_dly   = 30;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_eps_req", eps_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        run2(100, 2048, 512, 1, 0,  7, -3, 5, 0, 2, 0);

        for (int r = 0; r < 16; r++) begin
            int b;
            b = (r % 2 == 0) ? 12 : W;
            run2(rnd(W), rnd(b), rnd(b), $urandom_range(0, 3), $urandom_range(0, 3),
                 rnd(W), rnd(b), rnd(b), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
